// File: rtl/lbc_pkg.sv
// Shared constants for the linear block code stream encoder: default geometry
// and the (38,32) parity matrix.
package lbc_pkg;

  localparam int LBC_K_DEF         = 32;
  localparam int LBC_R_DEF         = 6;
  localparam int LBC_LANE_W_DEF    = 8;
  localparam int LBC_PIPE_DEF      = 3;
  localparam int LBC_OUT_DEPTH_DEF = 2;

  function automatic int lbc_cw_width(input int k, input int r);
    return k + r;
  endfunction

  // Column i (parity bits touched by data bit i) is the i-th R-bit value of
  // Hamming weight >= 2 in ascending order, so every column is distinct.
  function automatic logic [LBC_R_DEF*LBC_K_DEF-1:0] lbc_build_p();
    logic [LBC_R_DEF*LBC_K_DEF-1:0] p;
    int col;
    int w;
    p   = '0;
    col = 0;
    for (int v = 3; v < (1 << LBC_R_DEF); v++) begin
      w = 0;
      for (int b = 0; b < LBC_R_DEF; b++) w += (v >> b) & 1;
      if (w >= 2 && col < LBC_K_DEF) begin
        for (int j = 0; j < LBC_R_DEF; j++)
          if (((v >> j) & 1) == 1) p[j*LBC_K_DEF + col] = 1'b1;
        col++;
      end
    end
    return p;
  endfunction

  localparam logic [LBC_R_DEF*LBC_K_DEF-1:0] LBC_P_38_32 = lbc_build_p();

endpackage

// File: rtl/lbc_sync_fifo.sv
// Synchronous FIFO for finished codewords; push while full is legal only
// together with a pop.
module lbc_sync_fifo
  import lbc_pkg::*;
#(
  parameter int WIDTH = 38,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/lbc_stream_encoder.sv
// Streaming systematic block encoder: assembles lane beats into a message,
// computes parity through a pipelined XOR tree and buffers codewords.
module lbc_stream_encoder
  import lbc_pkg::*;
#(
  parameter int K         = LBC_K_DEF,
  parameter int R         = LBC_R_DEF,
  parameter int LANE_W    = LBC_LANE_W_DEF,
  parameter int PIPE      = LBC_PIPE_DEF,
  parameter int OUT_DEPTH = LBC_OUT_DEPTH_DEF,
  parameter logic [R*K-1:0] P_MATRIX = LBC_P_38_32,
  localparam int N = lbc_cw_width(K, R)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enc_en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [LANE_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [N-1:0]      m_data,
  output logic [15:0]       word_cnt
);

  if (K % LANE_W != 0) begin : g_bad_k
    $error("K must be a multiple of LANE_W");
  end
  if (PIPE < 1 || PIPE > 4) begin : g_bad_pipe
    $error("PIPE must be in 1..4");
  end
  if (OUT_DEPTH < 2 || OUT_DEPTH > 8) begin : g_bad_depth
    $error("OUT_DEPTH must be in 2..8");
  end

  localparam int BEATS = K / LANE_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int L     = (K > 1) ? $clog2(K) : 1;
  localparam int KP    = 1 << L;

  logic [BW-1:0]  beat_q;
  logic [K-1:0]   asm_q;
  logic           asm_full_q;
  logic           asm_en_q;
  logic           s_acc;
  logic           beat_last;
  logic           load0;

  logic [PIPE-1:0]         v_q;
  logic [PIPE-1:0]         v_in;
  logic [PIPE-1:0]         rdy;
  logic [K-1:0]            msg_q   [PIPE];
  logic [K-1:0]            msg_in  [PIPE];
  logic [R-1:0][KP-1:0]    part_q  [PIPE];
  logic [R-1:0][KP-1:0]    part_in [PIPE];
  logic [R-1:0]            parity;

  logic           fifo_full;
  logic           fifo_empty;
  logic [N-1:0]   fifo_rdata;
  logic           out_room;
  logic           push;
  logic           pop;

  function automatic logic [KP-1:0] fold(input logic [KP-1:0] p, input int n);
    logic [KP-1:0] t;
    logic [KP-1:0] u;
    t = p;
    for (int l = 0; l < n; l++) begin
      u = '0;
      for (int i = 0; i < KP / 2; i++) u[i] = t[2*i] ^ t[2*i+1];
      t = u;
    end
    return t;
  endfunction

  assign beat_last = (beat_q == BW'(BEATS - 1));
  assign load0     = asm_full_q && rdy[0];
  assign s_ready   = !rst && (!asm_full_q || load0);
  assign s_acc     = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q     <= '0;
      asm_full_q <= 1'b0;
      asm_en_q   <= 1'b0;
    end else begin
      if (load0) asm_full_q <= 1'b0;
      if (s_acc) begin
        asm_q[int'(beat_q)*LANE_W +: LANE_W] <= s_data;
        if (beat_last) begin
          beat_q     <= '0;
          asm_full_q <= 1'b1;
          asm_en_q   <= enc_en;
        end else begin
          beat_q <= beat_q + BW'(1);
        end
      end
    end
  end

  // A stage may load whenever some stage at or beyond it is empty, so bubbles
  // collapse while the output side is stalled.
  assign out_room = !fifo_full || pop;
  always_comb begin
    v_in = '0;
    rdy  = '0;
    for (int s = 0; s < PIPE; s++) begin
      v_in[s] = (s == 0) ? asm_full_q : v_q[(s > 0) ? s - 1 : 0];
      rdy[s]  = out_room || !(&(v_q | PIPE'((1 << s) - 1)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      for (int s = 0; s < PIPE; s++)
        if (rdy[s]) v_q[s] <= v_in[s];
    end
  end

  for (genvar s = 0; s < PIPE; s++) begin : g_stage
    localparam int NLV = (L * (s + 1)) / PIPE - (L * s) / PIPE;
    if (s == 0) begin : g_head
      assign msg_in[s] = asm_q;
      for (genvar j = 0; j < R; j++) begin : g_mask
        assign part_in[s][j] = asm_en_q ? KP'(asm_q & P_MATRIX[j*K +: K]) : '0;
      end
    end else begin : g_body
      assign msg_in[s]  = msg_q[s-1];
      assign part_in[s] = part_q[s-1];
    end
    always_ff @(posedge clk) begin
      if (rdy[s]) begin
        msg_q[s] <= msg_in[s];
        for (int j = 0; j < R; j++) part_q[s][j] <= fold(part_in[s][j], NLV);
      end
    end
  end

  always_comb begin
    parity = '0;
    for (int j = 0; j < R; j++) parity[j] = ^part_q[PIPE-1][j];
  end

  assign push = v_q[PIPE-1] && out_room;

  lbc_sync_fifo #(
    .WIDTH (N),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({msg_q[PIPE-1], parity}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_valid = !rst && !fifo_empty;
  assign m_data  = m_valid ? fifo_rdata : '0;
  assign pop     = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (rst)      word_cnt <= '0;
    else if (pop) word_cnt <= word_cnt + 16'd1;
  end

endmodule

// File: tb/tb_lbc_stream_encoder.sv
// Directed and randomized checks of lbc_stream_encoder at default parameters.
module tb_lbc_stream_encoder;

  localparam logic [191:0] PM = lbc_pkg::LBC_P_38_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        enc_en;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        m_valid;
  logic        m_ready;
  logic [37:0] m_data;
  logic [15:0] word_cnt;

  logic        rand_rdy = 1'b0;
  logic        rdy_rand = 1'b1;
  logic        rdy_force = 1'b1;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_sent = 0;
  int          stalls = 0;
  logic [37:0] exp_q [$];

  assign m_ready = rand_rdy ? rdy_rand : rdy_force;

  always #5 clk = ~clk;

  lbc_stream_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .enc_en   (enc_en),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .word_cnt (word_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] golden(input logic [31:0] msg, input logic en);
    logic [5:0] p;
    for (int j = 0; j < 6; j++) p[j] = ^(msg & PM[j*32 +: 32]);
    if (!en) p = '0;
    return {msg, p};
  endfunction

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  task automatic exp_push(input logic [37:0] cw);
    exp_q.push_back(cw);
    n_sent++;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!s_ready) begin
      stalls++;
      n++;
      if (n > 300) begin
        chk("s_ready_timeout", 64'(s_ready), 64'd1);
        finish_sim();
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] msg, input logic [3:0] en_mask, input int gap_pct);
    for (int b = 0; b < 4; b++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_valid = 1'b1;
      s_data  = msg[8*b +: 8];
      enc_en  = en_mask[b];
      wait_accept();
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("word_cnt", 64'(word_cnt), 64'(n_sent[15:0]));
  endtask

  // Codewords are taken off the bus mid-cycle; the handshake completes on the next edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else if (m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("cw_extra", 64'(exp_q.size()), 64'd1);
      else chk("codeword", 64'(m_data), 64'(exp_q.pop_front()));
    end
  end

  always @(posedge clk) begin
    #1;
    rdy_rand = ($urandom_range(3) != 0);
  end

  initial begin
    int cyc;
    int acc;
    int byte_n;
    int wc0;
    int mv_seen;
    logic [31:0] msg;
    logic [3:0]  en_mask;
    logic [37:0] first_exp;

    rst = 1'b1; s_valid = 1'b0; s_data = '0; enc_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_word_cnt", 64'(word_cnt), 64'd0);
    rst = 1'b0;
    #1;
    chk("s_ready_after_rst", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;

    // zero message and first-codeword latency
    exp_push(38'h0);
    send_word(32'h0, 4'hF, 0);
    cyc = 0;
    while (!m_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency", 64'(cyc), 64'd4);
    drain();

    // hand-computed parity vectors and enc_en sampling on the last beat
    exp_push(38'h00_0000_0043); send_word(32'h0000_0001, 4'hF, 0);
    exp_push(38'h00_0000_400D); send_word(32'h0000_0100, 4'hF, 0);
    exp_push(38'h00_0000_404E); send_word(32'h0000_0101, 4'hF, 0);
    exp_push(38'h37_AB6F_BBC0); send_word(32'hDEAD_BEEF, 4'h0, 0);
    exp_push(38'h37_AB6F_BBC0); send_word(32'hDEAD_BEEF, 4'h7, 0);
    exp_push(38'h00_0000_0043); send_word(32'h0000_0001, 4'h8, 0);
    drain();

    // back-to-back words with the sink always ready never stall the input
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      msg = 32'h1357_9BDF ^ (32'h0101_0101 * 32'(i));
      exp_push(golden(msg, 1'b1));
      send_word(msg, 4'hF, 0);
    end
    chk("tput_stalls", 64'(stalls), 64'd0);
    drain();

    // sink stalled: capacity is assembler + pipeline + buffer = 6 words
    rdy_force = 1'b0;
    wc0 = n_sent;
    acc = 0;
    byte_n = 0;
    for (int c = 0; c < 40; c++) begin
      s_valid = 1'b1;
      s_data  = byte_n[7:0];
      enc_en  = 1'b1;
      @(negedge clk);
      if (s_ready) begin
        acc++;
        byte_n++;
        if (byte_n % 4 == 0)
          exp_push(golden({8'(byte_n-1), 8'(byte_n-2), 8'(byte_n-3), 8'(byte_n-4)}, 1'b1));
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    chk("bp_beats", 64'(acc), 64'd24);
    chk("bp_s_ready", 64'(s_ready), 64'd0);
    chk("bp_m_valid", 64'(m_valid), 64'd1);
    first_exp = exp_q[0];
    chk("bp_hold_data", 64'(m_data), 64'(first_exp));
    chk("bp_word_cnt", 64'(word_cnt), 64'(16'(wc0)));
    rdy_force = 1'b1;
    drain();

    // reset mid-word with two words in flight
    rdy_force = 1'b0;
    send_word(32'hAAAA_5555, 4'hF, 0);
    send_word(32'h1234_5678, 4'hF, 0);
    s_valid = 1'b1; s_data = 8'hC1; enc_en = 1'b1; wait_accept();
    s_data = 8'hC2; wait_accept();
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    n_sent = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_word_cnt", 64'(word_cnt), 64'd0);
    chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
    rst = 1'b0;
    rdy_force = 1'b1;
    s_valid = 1'b1; s_data = 8'h11; enc_en = 1'b1; wait_accept();
    s_data = 8'h22; wait_accept();
    s_valid = 1'b0;
    mv_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (m_valid) mv_seen++;
    end
    chk("post_rst_no_m_valid", 64'(mv_seen), 64'd0);
    exp_push(golden(32'h4433_2211, 1'b1));
    s_valid = 1'b1; s_data = 8'h33; wait_accept();
    s_data = 8'h44; wait_accept();
    s_valid = 1'b0;
    drain();

    // random messages, random input gaps and sink stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      msg     = $urandom;
      en_mask = {($urandom_range(7) != 0), 3'($urandom_range(7))};
      exp_push(golden(msg, en_mask[3]));
      send_word(msg, en_mask, 12);
    end
    rand_rdy = 1'b0;
    rdy_force = 1'b1;
    drain();

    finish_sim();
  end

endmodule
